// File: rtl/reorder_buffer_pkg.sv
// Shared widths and index types for the reorder buffer.
// Exposes the entry count, index, data and register widths plus a wrapping
// index increment helper.
package reorder_buffer_pkg;

    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned ROB_W     = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned CNT_W     = ROB_W + 1;

    typedef logic [ROB_W-1:0]  rob_idx_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [CNT_W-1:0]  rob_cnt_t;

    // Power-of-two depth, so the natural 4-bit overflow gives the 15 -> 0 wrap.
    function automatic rob_idx_t idx_inc(input rob_idx_t i);
        return i + ROB_W'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer.
// Allocates an entry per issued instruction, captures CDB results, retires in
// program order and flushes everything on a branch mispredict at commit.
// Ports:
//   clk, rst (async, active-low), rdy (0 = freeze)
//   issue_*        : allocation request; rob_full / issue_rob_num back to issue
//   rsN_rob_num    : operand lookup tags; rsN_ready / rsN_value (CDB bypassed)
//   cdb_*          : result broadcast
//   has_from_rob, dest_reg_num, in_reg_data : register commit pulse
//   store_commit, store_commit_rob_num      : store release pulse
//   has_misbranch, redirect_pc              : flush pulse and restart PC
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             issue_is_branch,
    input  logic             issue_is_store,
    input  logic             issue_pred_taken,
    output logic             rob_full,
    output logic [ROB_W-1:0] issue_rob_num,
    input  logic [ROB_W-1:0] rs1_rob_num,
    input  logic [ROB_W-1:0] rs2_rob_num,
    output logic             rs1_ready,
    output logic             rs2_ready,
    output logic [DATA_W-1:0] rs1_value,
    output logic [DATA_W-1:0] rs2_value,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_rob_num,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic             cdb_taken,
    input  logic [DATA_W-1:0] cdb_target,
    output logic             has_from_rob,
    output logic [REG_W-1:0] dest_reg_num,
    output logic [DATA_W-1:0] in_reg_data,
    output logic             store_commit,
    output logic [ROB_W-1:0] store_commit_rob_num,
    output logic             has_misbranch,
    output logic [DATA_W-1:0] redirect_pc
);

    // Per-field entry storage
    logic [ROB_DEPTH-1:0] busy_q, busy_d;
    logic [ROB_DEPTH-1:0] ready_q, ready_d;
    logic [ROB_DEPTH-1:0] is_branch_q, is_branch_d;
    logic [ROB_DEPTH-1:0] is_store_q, is_store_d;
    logic [ROB_DEPTH-1:0] pred_q, pred_d;
    logic [ROB_DEPTH-1:0] taken_q, taken_d;
    reg_idx_t             rd_q     [ROB_DEPTH];
    reg_idx_t             rd_d     [ROB_DEPTH];
    data_t                data_q   [ROB_DEPTH];
    data_t                data_d   [ROB_DEPTH];
    data_t                target_q [ROB_DEPTH];
    data_t                target_d [ROB_DEPTH];

    rob_idx_t head_q, head_d, tail_q, tail_d;
    rob_cnt_t count_q, count_d;

    // Registered commit outputs
    logic     commit_q, commit_d;
    reg_idx_t dest_q, dest_d;
    data_t    wdata_q, wdata_d;
    logic     st_q, st_d;
    rob_idx_t st_idx_q, st_idx_d;
    logic     misb_q, misb_d;
    data_t    pc_q, pc_d;

    logic do_issue_c, do_commit_c, mispredict_c;

    assign rob_full      = (count_q == CNT_W'(ROB_DEPTH));
    assign issue_rob_num = tail_q;

    // Operand lookup with same-cycle CDB bypass
    always_comb begin
        rs1_ready = ready_q[rs1_rob_num];
        rs1_value = data_q[rs1_rob_num];
        rs2_ready = ready_q[rs2_rob_num];
        rs2_value = data_q[rs2_rob_num];
        if (cdb_valid && (cdb_rob_num == rs1_rob_num)) begin
            rs1_ready = 1'b1;
            rs1_value = cdb_data;
        end
        if (cdb_valid && (cdb_rob_num == rs2_rob_num)) begin
            rs2_ready = 1'b1;
            rs2_value = cdb_data;
        end
    end

    // Commit decision uses registered state only, so a same-cycle CDB write
    // to the head cannot retire it until the following edge.
    assign do_issue_c   = issue_valid && !rob_full;
    assign do_commit_c  = (count_q != '0) && busy_q[head_q] && ready_q[head_q];
    assign mispredict_c = do_commit_c && is_branch_q[head_q]
                          && (taken_q[head_q] != pred_q[head_q]);

    // Next-state: CDB capture, allocation, retirement, then flush override
    always_comb begin
        busy_d      = busy_q;
        ready_d     = ready_q;
        is_branch_d = is_branch_q;
        is_store_d  = is_store_q;
        pred_d      = pred_q;
        taken_d     = taken_q;
        rd_d        = rd_q;
        data_d      = data_q;
        target_d    = target_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        commit_d    = 1'b0;
        dest_d      = '0;
        wdata_d     = '0;
        st_d        = 1'b0;
        st_idx_d    = '0;
        misb_d      = 1'b0;
        pc_d        = '0;

        if (rdy) begin
            if (cdb_valid && busy_q[cdb_rob_num]) begin
                ready_d[cdb_rob_num]  = 1'b1;
                data_d[cdb_rob_num]   = cdb_data;
                taken_d[cdb_rob_num]  = cdb_taken;
                target_d[cdb_rob_num] = cdb_target;
            end

            if (do_issue_c) begin
                busy_d[tail_q]      = 1'b1;
                ready_d[tail_q]     = 1'b0;
                rd_d[tail_q]        = issue_rd;
                is_branch_d[tail_q] = issue_is_branch;
                is_store_d[tail_q]  = issue_is_store;
                pred_d[tail_q]      = issue_pred_taken;
                tail_d              = idx_inc(tail_q);
            end

            if (do_commit_c) begin
                busy_d[head_q] = 1'b0;
                head_d         = idx_inc(head_q);
                commit_d       = 1'b1;
                dest_d         = rd_q[head_q];
                wdata_d        = data_q[head_q];
                if (is_store_q[head_q]) begin
                    st_d     = 1'b1;
                    st_idx_d = head_q;
                end
            end

            count_d = count_q + CNT_W'(do_issue_c) - CNT_W'(do_commit_c);

            // Flush discards every entry, including one issued this cycle
            if (mispredict_c) begin
                misb_d  = 1'b1;
                pc_d    = target_q[head_q];
                busy_d  = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= '0;
            ready_q     <= '0;
            is_branch_q <= '0;
            is_store_q  <= '0;
            pred_q      <= '0;
            taken_q     <= '0;
            rd_q        <= '{default: '0};
            data_q      <= '{default: '0};
            target_q    <= '{default: '0};
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            commit_q    <= 1'b0;
            dest_q      <= '0;
            wdata_q     <= '0;
            st_q        <= 1'b0;
            st_idx_q    <= '0;
            misb_q      <= 1'b0;
            pc_q        <= '0;
        end else begin
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            is_branch_q <= is_branch_d;
            is_store_q  <= is_store_d;
            pred_q      <= pred_d;
            taken_q     <= taken_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            target_q    <= target_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            commit_q    <= commit_d;
            dest_q      <= dest_d;
            wdata_q     <= wdata_d;
            st_q        <= st_d;
            st_idx_q    <= st_idx_d;
            misb_q      <= misb_d;
            pc_q        <= pc_d;
        end
    end

    assign has_from_rob         = commit_q;
    assign dest_reg_num         = dest_q;
    assign in_reg_data          = wdata_q;
    assign store_commit         = st_q;
    assign store_commit_rob_num = st_idx_q;
    assign has_misbranch        = misb_q;
    assign redirect_pc          = pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a commit-order scoreboard.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_is_branch = 1'b0;
    logic        issue_is_store = 1'b0;
    logic        issue_pred_taken = 1'b0;
    logic        rob_full;
    logic [3:0]  issue_rob_num;
    logic [3:0]  rs1_rob_num = '0;
    logic [3:0]  rs2_rob_num = '0;
    logic        rs1_ready, rs2_ready;
    logic [31:0] rs1_value, rs2_value;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_rob_num = '0;
    logic [31:0] cdb_data = '0;
    logic        cdb_taken = 1'b0;
    logic [31:0] cdb_target = '0;
    logic        has_from_rob;
    logic [4:0]  dest_reg_num;
    logic [31:0] in_reg_data;
    logic        store_commit;
    logic [3:0]  store_commit_rob_num;
    logic        has_misbranch;
    logic [31:0] redirect_pc;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_is_branch(issue_is_branch), .issue_is_store(issue_is_store),
        .issue_pred_taken(issue_pred_taken),
        .rob_full(rob_full), .issue_rob_num(issue_rob_num),
        .rs1_rob_num(rs1_rob_num), .rs2_rob_num(rs2_rob_num),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .cdb_valid(cdb_valid), .cdb_rob_num(cdb_rob_num), .cdb_data(cdb_data),
        .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .has_from_rob(has_from_rob), .dest_reg_num(dest_reg_num),
        .in_reg_data(in_reg_data), .store_commit(store_commit),
        .store_commit_rob_num(store_commit_rob_num),
        .has_misbranch(has_misbranch), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        st;
        logic [3:0]  idx;
        logic        misb;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] pd  [16];
    logic [31:0] ptg [16];
    logic        ptk [16];
    logic [3:0]  m_tail = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        found;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Allocate one entry; its eventual CDB payload is planned now.
    task automatic do_issue(input logic [4:0] rd, input logic br, input logic st,
                            input logic pred, input logic [31:0] data,
                            input logic tk, input logic [31:0] tg);
        exp_t e;
        chk("issue_rob_num", 64'(issue_rob_num), 64'(m_tail));
        pd[m_tail]  = data;
        ptk[m_tail] = tk;
        ptg[m_tail] = tg;
        e.rd   = rd;
        e.data = data;
        e.st   = st;
        e.idx  = m_tail;
        e.misb = br && (tk != pred);
        e.pc   = tg;
        sb.push_back(e);
        issue_valid      = 1'b1;
        issue_rd         = rd;
        issue_is_branch  = br;
        issue_is_store   = st;
        issue_pred_taken = pred;
        tick();
        issue_valid = 1'b0;
        m_tail      = m_tail + 4'd1;
    endtask

    task automatic do_cdb(input logic [3:0] idx);
        cdb_valid   = 1'b1;
        cdb_rob_num = idx;
        cdb_data    = pd[idx];
        cdb_taken   = ptk[idx];
        cdb_target  = ptg[idx];
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sb.delete();
        m_tail = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Scoreboard: every commit pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (rst && has_from_rob) begin
            if (sb.size() == 0) begin
                chk("spurious_commit", 64'(has_from_rob), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("commit_rd", 64'(dest_reg_num), 64'(mon_e.rd));
                chk("commit_data", 64'(in_reg_data), 64'(mon_e.data));
                chk("commit_store", 64'(store_commit), 64'(mon_e.st));
                if (mon_e.st) chk("store_idx", 64'(store_commit_rob_num), 64'(mon_e.idx));
                chk("commit_misbranch", 64'(has_misbranch), 64'(mon_e.misb));
                if (mon_e.misb) begin
                    chk("redirect_pc", 64'(redirect_pc), 64'(mon_e.pc));
                    sb.delete();
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_has_from_rob", 64'(has_from_rob), 64'd0);
        chk("rst_issue_rob_num", 64'(issue_rob_num), 64'd0);
        chk("rst_rob_full", 64'(rob_full), 64'd0);
        chk("rst_store_commit", 64'(store_commit), 64'd0);
        chk("rst_has_misbranch", 64'(has_misbranch), 64'd0);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        rst = 1'b1;
        tick();

        // In-order commit with out-of-order completion
        do_issue(5'd3, 1'b0, 1'b0, 1'b0, 32'h11, 1'b0, 32'h0);
        do_issue(5'd4, 1'b0, 1'b0, 1'b0, 32'h22, 1'b0, 32'h0);
        do_cdb(4'd1);
        do_cdb(4'd0);
        chk("no_commit_same_cycle", 64'(has_from_rob), 64'd0);
        tick();
        chk("c0_valid", 64'(has_from_rob), 64'd1);
        chk("c0_rd", 64'(dest_reg_num), 64'd3);
        chk("c0_data", 64'(in_reg_data), 64'h11);
        tick();
        chk("c1_valid", 64'(has_from_rob), 64'd1);
        chk("c1_rd", 64'(dest_reg_num), 64'd4);
        chk("c1_data", 64'(in_reg_data), 64'h22);
        tick();
        chk("c_pulse_end", 64'(has_from_rob), 64'd0);

        // Asynchronous reset with live entries and a commit pulse high
        for (int i = 0; i < 5; i++)
            do_issue(5'(10 + i), 1'b0, 1'b0, 1'b0, 32'h100 + 32'(i), 1'b0, 32'h0);
        do_cdb(4'd2);
        tick();
        chk("pre_reset_commit", 64'(has_from_rob), 64'd1);
        rst = 1'b0;
        #1;
        chk("async_has_from_rob", 64'(has_from_rob), 64'd0);
        chk("async_dest", 64'(dest_reg_num), 64'd0);
        chk("async_data", 64'(in_reg_data), 64'd0);
        chk("async_issue_rob_num", 64'(issue_rob_num), 64'd0);
        chk("async_rob_full", 64'(rob_full), 64'd0);
        sb.delete();
        m_tail = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Fill, reject overflow, wrap the tail
        for (int i = 0; i < 16; i++)
            do_issue(5'(i + 1), 1'b0, (i == 7), 1'b0, 32'h1000 + 32'(i), 1'b0, 32'h0);
        chk("full_flag", 64'(rob_full), 64'd1);
        chk("full_tail", 64'(issue_rob_num), 64'd0);
        issue_valid = 1'b1;
        issue_rd    = 5'd31;
        tick();
        issue_valid = 1'b0;
        chk("overflow_ignored_idx", 64'(issue_rob_num), 64'd0);
        chk("overflow_still_full", 64'(rob_full), 64'd1);
        do_cdb(4'd0);
        chk("full_until_commit", 64'(rob_full), 64'd1);
        tick();
        chk("wrap_commit", 64'(has_from_rob), 64'd1);
        chk("wrap_not_full", 64'(rob_full), 64'd0);
        do_issue(5'd20, 1'b0, 1'b0, 1'b0, 32'hBEEF, 1'b0, 32'h0);
        chk("refull", 64'(rob_full), 64'd1);
        for (int i = 1; i < 16; i++) do_cdb(4'(i));
        do_cdb(4'd0);
        wait_drain();

        // Mispredict at entry 2 with three younger entries
        do_reset();
        do_issue(5'd1, 1'b0, 1'b0, 1'b0, 32'h1, 1'b0, 32'h0);
        do_issue(5'd2, 1'b0, 1'b0, 1'b0, 32'h2, 1'b0, 32'h0);
        do_issue(5'd0, 1'b1, 1'b0, 1'b0, 32'h2008, 1'b1, 32'h1040);
        do_issue(5'd5, 1'b0, 1'b0, 1'b0, 32'h5, 1'b0, 32'h0);
        do_issue(5'd6, 1'b0, 1'b0, 1'b0, 32'h6, 1'b0, 32'h0);
        do_issue(5'd7, 1'b0, 1'b0, 1'b0, 32'h7, 1'b0, 32'h0);
        do_cdb(4'd0);
        do_cdb(4'd1);
        do_cdb(4'd2);
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (has_misbranch) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("misbranch_seen", 64'(found), 64'd1);
        chk("misbranch_pc", 64'(redirect_pc), 64'h1040);
        chk("flush_tail", 64'(issue_rob_num), 64'd0);
        tick();
        chk("misbranch_one_cycle", 64'(has_misbranch), 64'd0);
        chk("no_commit_after_flush", 64'(has_from_rob), 64'd0);
        chk("flush_not_full", 64'(rob_full), 64'd0);
        chk("flush_tail_hold", 64'(issue_rob_num), 64'd0);
        m_tail = '0;
        do_cdb(4'd3);
        tick();
        tick();
        chk("flushed_entry_silent", 64'(has_from_rob), 64'd0);

        // CDB bypass on operand lookup
        for (int i = 0; i < 6; i++)
            do_issue(5'(i + 1), 1'b0, (i == 2), 1'b0,
                     (i == 5) ? 32'hABCD : 32'h300 + 32'(i), 1'b0, 32'h0);
        rs1_rob_num = 4'd5;
        rs2_rob_num = 4'd4;
        #1;
        chk("rs1_not_ready", 64'(rs1_ready), 64'd0);
        cdb_valid   = 1'b1;
        cdb_rob_num = 4'd5;
        cdb_data    = pd[5];
        cdb_taken   = 1'b0;
        cdb_target  = 32'h0;
        #1;
        chk("bypass_ready", 64'(rs1_ready), 64'd1);
        chk("bypass_value", 64'(rs1_value), 64'hABCD);
        chk("bypass_rs2_not_ready", 64'(rs2_ready), 64'd0);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("stored_ready", 64'(rs1_ready), 64'd1);
        chk("stored_value", 64'(rs1_value), 64'hABCD);

        // rdy stall with a ready head; issue attempts are frozen too
        do_cdb(4'd0);
        rdy         = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_no_commit", 64'(has_from_rob), 64'd0);
            chk("stall_tail", 64'(issue_rob_num), 64'd6);
        end
        rdy         = 1'b1;
        issue_valid = 1'b0;
        tick();
        chk("resume_commit", 64'(has_from_rob), 64'd1);
        chk("resume_rd", 64'(dest_reg_num), 64'd1);
        chk("resume_data", 64'(in_reg_data), 64'h300);
        for (int i = 1; i < 5; i++) do_cdb(4'(i));
        wait_drain();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
